updown_sweep_ctrl: RTL
======================

Name: updown_sweep_ctrl

Overview:
Sequencer for the team's synchronous up/down counter datapath. It sweeps a WIDTH-bit count from a programmable low bound to a high bound and back, repeated for a programmed number of sweeps. It drives the updown direction line (0 = up, 1 = down) and the count value. It reports busy, done and a configuration error, and supports pause and abort.

Parameters:
WIDTH, 3, counter width in bits
SWEEPS_W, 4, width of sweep-count input and status counter
DWELL_CYCLES, 2, extra hold cycles at each turning point (used only with DWELL_EN)

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous active-low reset
start  input  1  single-cycle request to begin; sampled only in IDLE
abort  input  1  stop immediately and return to IDLE
pause  input  1  level; freezes count, state and dwell timer while high
lo  input  WIDTH  lower bound; latched on accepted start
hi  input  WIDTH  upper bound; latched on accepted start
nsweeps  input  SWEEPS_W  number of lo->hi->lo sweeps; latched on accepted start
q  output  WIDTH  current count
updown  output  1  direction: 0 = counting up, 1 = counting down
busy  output  1  high from the cycle after an accepted start until DONE
done  output  1  one-cycle pulse when the final sweep completes
err  output  1  one-cycle pulse when a start is rejected
sweep_cnt  output  SWEEPS_W  completed sweeps in the current run

Behaviour:
- Reset (rst=0, asynchronous): state IDLE; q=0, updown=0, busy=0, done=0, err=0, sweep_cnt=0; latched lo/hi/nsweeps cleared to 0.
- All outputs are registered. State changes take effect on the rising clk edge after the condition is sampled.
- States: IDLE, UP, DOWN, DONE. DWELL_HI and DWELL_LO exist only with DWELL_EN.
- Priority, high to low: abort, then pause, then normal operation. start is ignored in any state except IDLE.
- IDLE, start=1:
  - If lo >= hi or nsweeps == 0: err=1 for one cycle; stay in IDLE; q unchanged.
  - Otherwise: latch the bounds; q<=lo, sweep_cnt<=0, busy<=1, updown<=0; go to UP.
- UP: q<=q+1 each unpaused cycle. In the cycle q becomes hi, state becomes DOWN and updown becomes 1. The value hi is held for exactly one cycle, and updown=1 during it.
- DOWN: q<=q-1 each unpaused cycle. In the cycle q becomes lo, the sweep is complete and sweep_cnt<=sweep_cnt+1.
  - If sweep_cnt+1 == nsweeps: go to DONE.
  - Otherwise: go to UP with updown=0.
- DONE: lasts one cycle. done=1, busy=0, q=lo, updown=0. Then go to IDLE; done returns to 0.
- Sequence per sweep: lo, lo+1, ..., hi, hi-1, ..., lo. Sweep length is 2*(hi-lo) cycles. The shared lo value counts once between consecutive sweeps.
- hi-lo == 1 is legal and gives alternating counts.
- No wrap-around: lo < hi is guaranteed by the start check, so q never passes hi or lo.
- pause=1 in UP/DOWN/DWELL: q, state, updown, sweep_cnt and dwell timer all hold; busy stays 1. pause has no effect in IDLE or DONE.
- abort=1 in any non-IDLE state: next state IDLE; busy=0; q and sweep_cnt hold their values; no done pulse.
- abort=1 in IDLE: no effect; abort also overrides a simultaneous start.
- Mid-run changes to lo, hi or nsweeps have no effect until the next accepted start.

Optional Feature:
DWELL_EN
- Defined:
  - Arriving at hi enters DWELL_HI: q=hi and updown=1 held for DWELL_CYCLES extra cycles, then DOWN continues.
  - Arriving at lo between sweeps (not after the final sweep) enters DWELL_LO: q=lo and updown=0 held for DWELL_CYCLES extra cycles, then UP.
  - A dwell timer counts the hold cycles; pause freezes it; abort clears it.
- Undefined: the DWELL states, the timer and the DWELL_CYCLES logic are absent; turnarounds are immediate as described above.

Test Plan:
- Basic run: lo=0, hi=2, nsweeps=1, start pulse -> q=0,1,2,1,0 on consecutive cycles. updown=0,0,1,1,1. done=1 in the cycle after q returns to 0, with q=0. busy=0 from the done cycle.
- Multiple sweeps: lo=1, hi=3, nsweeps=3 -> q follows 1,2,3,2,1,2,3,2,1,2,3,2,1. sweep_cnt steps 1,2,3. A single done pulse is generated, 12 cycles of counting after the first q=1.
- Config errors: (lo=5, hi=5, nsweeps=2) and then (lo=0, hi=7, nsweeps=0) -> err pulses once for each; state stays IDLE; busy=0; q unchanged.
- Pause: lo=0, hi=7, nsweeps=1; hold pause for 3 cycles starting at q=4 in UP -> q=4 and updown=0 for those 3 cycles, then continues 5,6,7. Total run is 3 cycles longer.
- Abort and reset: abort at q=6 in DOWN -> IDLE next edge, q=6, busy=0, no done. Asserting rst mid-run -> immediately q=0, busy=0, updown=0, sweep_cnt=0. start while busy=1 is ignored.
- With DWELL_EN and DWELL_CYCLES=2: lo=0, hi=2, nsweeps=2 -> q=0,1,2,2,2,1,0,0,0,1,2,2,2,1,0, then done. There is no dwell after the final return to lo.

Source files
------------

// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for the up/down counter datapath: lo -> hi -> lo, repeated nsweeps times.
// Optional turning-point dwell is enabled by defining DWELL_EN (hold length DWELL_CYCLES).
module updown_sweep_ctrl #(
    parameter int WIDTH        = 3,
    parameter int SWEEPS_W     = 4,
    parameter int DWELL_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                abort,
    input  logic                pause,
    input  logic [WIDTH-1:0]    lo,
    input  logic [WIDTH-1:0]    hi,
    input  logic [SWEEPS_W-1:0] nsweeps,
    output logic [WIDTH-1:0]    q,
    output logic                updown,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [SWEEPS_W-1:0] sweep_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_UP,
        S_DOWN,
        S_DONE
`ifdef DWELL_EN
        ,
        S_DWELL_HI,
        S_DWELL_LO
`endif
    } state_t;

    if (DWELL_CYCLES < 0) begin : g_bad_dwell
        $error("DWELL_CYCLES must be non-negative");
    end

    state_t              state_q, state_d;
    logic [WIDTH-1:0]    count_q, count_d;
    logic [WIDTH-1:0]    lo_q, lo_d;
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [SWEEPS_W-1:0] ns_q, ns_d;
    logic [SWEEPS_W-1:0] sweep_q, sweep_d;
    logic                updown_q, updown_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;

`ifdef DWELL_EN
    localparam int TW = (DWELL_CYCLES < 1) ? 1 : $clog2(DWELL_CYCLES + 1);
    logic [TW-1:0] timer_q, timer_d;
`endif

    logic [WIDTH-1:0]    count_inc;
    logic [WIDTH-1:0]    count_dec;
    logic [SWEEPS_W-1:0] sweep_inc;
    logic                holding;
    logic                step_up;
    logic                step_down;

    assign count_inc = count_q + 1'b1;
    assign count_dec = count_q - 1'b1;
    assign sweep_inc = sweep_q + 1'b1;
    assign holding   = pause && (state_q != S_IDLE) && (state_q != S_DONE);

    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        ns_d      = ns_q;
        sweep_d   = sweep_q;
        updown_d  = updown_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        err_d     = 1'b0;
        step_up   = 1'b0;
        step_down = 1'b0;
`ifdef DWELL_EN
        timer_d   = timer_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d  = S_IDLE;
            busy_d   = 1'b0;
            updown_d = 1'b0;
`ifdef DWELL_EN
            timer_d  = '0;
`endif
        end else if (!holding) begin
            case (state_q)
                S_IDLE: begin
                    if (start && !abort) begin
                        if ((lo >= hi) || (nsweeps == '0)) begin
                            err_d = 1'b1;
                        end else begin
                            lo_d     = lo;
                            hi_d     = hi;
                            ns_d     = nsweeps;
                            count_d  = lo;
                            sweep_d  = '0;
                            busy_d   = 1'b1;
                            updown_d = 1'b0;
                            state_d  = S_UP;
                        end
                    end
                end
                S_UP:   step_up   = 1'b1;
                S_DOWN: step_down = 1'b1;
                // The cycle showing the final lo has passed; announce completion.
                S_DONE: begin
                    state_d  = S_IDLE;
                    done_d   = 1'b1;
                    busy_d   = 1'b0;
                    updown_d = 1'b0;
                    count_d  = lo_q;
                end
`ifdef DWELL_EN
                S_DWELL_HI: begin
                    if (timer_q == TW'(DWELL_CYCLES)) begin
                        timer_d   = '0;
                        step_down = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
                S_DWELL_LO: begin
                    if (timer_q == TW'(DWELL_CYCLES)) begin
                        timer_d = '0;
                        step_up = 1'b1;
                    end else begin
                        timer_d = timer_q + 1'b1;
                    end
                end
`endif
                default: state_d = S_IDLE;
            endcase

            if (step_up) begin
                count_d  = count_inc;
                state_d  = S_UP;
                updown_d = 1'b0;
                if (count_inc == hi_q) begin
                    updown_d = 1'b1;
`ifdef DWELL_EN
                    state_d  = S_DWELL_HI;
`else
                    state_d  = S_DOWN;
`endif
                end
            end

            // Step down also runs when leaving a hi dwell, so hi-lo == 1 still closes the sweep.
            if (step_down) begin
                count_d  = count_dec;
                state_d  = S_DOWN;
                updown_d = 1'b1;
                if (count_dec == lo_q) begin
                    sweep_d = sweep_inc;
                    if (sweep_inc == ns_q) begin
                        state_d = S_DONE;
                    end else begin
                        updown_d = 1'b0;
`ifdef DWELL_EN
                        state_d  = S_DWELL_LO;
`else
                        state_d  = S_UP;
`endif
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            count_q  <= '0;
            lo_q     <= '0;
            hi_q     <= '0;
            ns_q     <= '0;
            sweep_q  <= '0;
            updown_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
`ifdef DWELL_EN
            timer_q  <= '0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            lo_q     <= lo_d;
            hi_q     <= hi_d;
            ns_q     <= ns_d;
            sweep_q  <= sweep_d;
            updown_q <= updown_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
`ifdef DWELL_EN
            timer_q  <= timer_d;
`endif
        end
    end

    assign q         = count_q;
    assign updown    = updown_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign sweep_cnt = sweep_q;

endmodule
